// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI controller register layout shared with its bus masters
package spi_pkg;

   // SPICnt bit positions; bits 15:8 are the SPICntHi register, 7:0 SPICntLo
   localparam int SPICNT_HI_LSB   = 8;
   localparam int SPICNT_START    = 15;
   localparam int SPICNT_BUS_MAP  = 14;
   localparam int SPICNT_DEVICE   = 13;
   localparam int SPICNT_CS       = 12;
   localparam int SPICNT_SLOW_CLK = 11;
   localparam int SPICNT_MODE_LSB = 9;
   localparam int SPICNT_LEN_MSB  = 8;

   localparam logic [7:0] FLASH_CMD_READ = 8'h03;

   typedef enum logic [1:0] {
      MODE_WRITE         = 2'd0,
      MODE_READ          = 2'd1,
      MODE_EXCHANGE      = 2'd2,
      MODE_WAIT_AND_READ = 2'd3
   } transfer_mode_t;

   typedef enum logic [0:0] {
      DEV_FLASH  = 1'b0,
      DEV_SDCARD = 1'b1
   } device_t;

   // Assemble the SPICntHi byte from its fields
   function automatic logic [7:0] spi_cnt_hi(input logic start, input logic bus_map,
                                             input device_t dev, input logic cs,
                                             input logic slow_clk, input transfer_mode_t mode,
                                             input logic len_msb);
      logic [7:0] hi;
      hi = '0;
      hi[SPICNT_START - SPICNT_HI_LSB]           = start;
      hi[SPICNT_BUS_MAP - SPICNT_HI_LSB]         = bus_map;
      hi[SPICNT_DEVICE - SPICNT_HI_LSB]          = dev;
      hi[SPICNT_CS - SPICNT_HI_LSB]              = cs;
      hi[SPICNT_SLOW_CLK - SPICNT_HI_LSB]        = slow_clk;
      hi[SPICNT_MODE_LSB - SPICNT_HI_LSB +: 2]   = mode;
      hi[SPICNT_LEN_MSB - SPICNT_HI_LSB]         = len_msb;
      return hi;
   endfunction

endpackage

// File: rtl/spi_flash_read_sequencer.sv
// rtl/spi_flash_read_sequencer.sv - drives the SPI controller through one flash read and streams the data
module spi_flash_read_sequencer
   import spi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int POLL_INTERVAL  = 4,
   parameter int RD_LAT         = 2
) (
   input  logic        FastClk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [23:0] FlashAddr,
   input  logic [8:0]  Len,
   input  logic        UseSlowClk,
   output logic [8:0]  BufAddr,
   output logic [7:0]  WriteData,
   output logic        WriteTXBuffer,
   output logic        WriteSPICntLo,
   output logic        WriteSPICntHi,
   output logic        RegWe,
   output logic        RegRe,
   input  logic [15:0] RXBufData,
   input  logic        SpiBusy,
   output logic [15:0] OutData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic        OutLast,
   output logic        Idle,
   output logic        Done,
   output logic        Error
);

   localparam int PW = $clog2(POLL_INTERVAL + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   // command phase shifts out opcode plus three address bytes: count-minus-one = 3
   localparam logic [7:0] CMD_XFER_LEN = 8'h03;

   typedef enum logic [3:0] {
      ST_IDLE, ST_LOAD_TX, ST_CMD_START, ST_CMD_WAIT, ST_RD_START,
      ST_RD_WAIT, ST_DESELECT, ST_FETCH, ST_FINISH
   } seq_state_t;

   seq_state_t state, state_d;

   logic [23:0]       addr_q;
   logic [8:0]        len_q;
   logic              slow_q;
   logic              err_q;
   logic [1:0]        step;
   logic [PW-1:0]     poll_cnt;
   logic [TW-1:0]     wait_cnt;
   logic              zero_seen;
   logic [RD_LAT-1:0] re_pipe;
   logic              rd_valid;
   logic              in_wait;
   logic              busy_clear;
   logic              wait_expired;
   logic              timeout;
   logic [7:0]        word_idx;
   logic              rd_pend;
   logic              out_valid_q;
   logic              out_last_q;
   logic [15:0]       out_data_q;

   assign rd_valid     = re_pipe[RD_LAT-1];
   assign in_wait      = (state == ST_CMD_WAIT) || (state == ST_RD_WAIT);
   assign busy_clear   = rd_valid && !SpiBusy && zero_seen;
   assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   assign OutData  = out_data_q;
   assign OutValid = out_valid_q;
   assign OutLast  = out_last_q;
   assign Error    = err_q;
   assign Idle     = (state == ST_IDLE);

   // State register
   always_ff @(posedge FastClk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   // Request capture on an accepted Start; Error is sticky until the next one
   always_ff @(posedge FastClk) begin
      if (Reset) begin
         addr_q <= '0;
         len_q  <= '0;
         slow_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (state == ST_IDLE && Start) begin
         addr_q <= FlashAddr;
         len_q  <= Len;
         slow_q <= UseSlowClk;
         err_q  <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end
   end

   // Write-step, poll cadence, timeout and busy history; all restart on each state change
   always_ff @(posedge FastClk) begin
      if (Reset || state_d != state) begin
         step      <= '0;
         poll_cnt  <= '0;
         wait_cnt  <= '0;
         zero_seen <= 1'b0;
         re_pipe   <= '0;
      end else begin
         step    <= step + 2'd1;
         re_pipe <= RD_LAT'({re_pipe, RegRe});
         if (in_wait) begin
            poll_cnt <= (poll_cnt == PW'(POLL_INTERVAL - 1)) ? '0 : poll_cnt + 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
            if (rd_valid) zero_seen <= !SpiBusy;
         end
      end
   end

   // Fetch datapath: one read in flight, one-word holding register toward the stream
   always_ff @(posedge FastClk) begin
      if (Reset || state != ST_FETCH) begin
         word_idx    <= '0;
         rd_pend     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (RegRe) rd_pend <= 1'b1;
         if (rd_pend && rd_valid) begin
            out_data_q  <= RXBufData;
            out_valid_q <= 1'b1;
            out_last_q  <= (word_idx == len_q[8:1]);
            rd_pend     <= 1'b0;
         end
         if (out_valid_q && OutReady) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_idx    <= word_idx + 8'd1;
         end
      end
   end

   // Next-state and register-bus strobes
   always_comb begin
      state_d       = state;
      BufAddr       = '0;
      WriteData     = '0;
      WriteTXBuffer = 1'b0;
      WriteSPICntLo = 1'b0;
      WriteSPICntHi = 1'b0;
      RegWe         = 1'b0;
      RegRe         = 1'b0;
      Done          = 1'b0;
      timeout       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) state_d = ST_LOAD_TX;
         end
         ST_LOAD_TX: begin
            RegWe         = 1'b1;
            WriteTXBuffer = 1'b1;
            BufAddr       = {7'd0, step};
            case (step)
               2'd0:    WriteData = FLASH_CMD_READ;
               2'd1:    WriteData = addr_q[23:16];
               2'd2:    WriteData = addr_q[15:8];
               default: WriteData = addr_q[7:0];
            endcase
            if (step == 2'd3) state_d = ST_CMD_START;
         end
         ST_CMD_START: begin
            RegWe = 1'b1;
            if (step == 2'd0) begin
               WriteSPICntLo = 1'b1;
               WriteData     = CMD_XFER_LEN;
            end else begin
               WriteSPICntHi = 1'b1;
               WriteData     = spi_cnt_hi(1'b1, 1'b1, DEV_FLASH, 1'b1, slow_q, MODE_WRITE, 1'b0);
               state_d       = ST_CMD_WAIT;
            end
         end
         ST_RD_START: begin
            RegWe = 1'b1;
            if (step == 2'd0) begin
               WriteSPICntLo = 1'b1;
               WriteData     = len_q[7:0];
            end else begin
               WriteSPICntHi = 1'b1;
               WriteData     = spi_cnt_hi(1'b1, 1'b1, DEV_FLASH, 1'b1, slow_q, MODE_READ, len_q[8]);
               state_d       = ST_RD_WAIT;
            end
         end
         ST_CMD_WAIT, ST_RD_WAIT: begin
            RegRe = (poll_cnt == '0);
            if (busy_clear) begin
               state_d = (state == ST_CMD_WAIT) ? ST_RD_START : ST_DESELECT;
            end else if (wait_expired) begin
               timeout = 1'b1;
               state_d = ST_DESELECT;
            end
         end
         ST_DESELECT: begin
            // drops cs and unmaps the buffer so received bytes appear at bus address 0
            RegWe         = 1'b1;
            WriteSPICntHi = 1'b1;
            WriteData     = 8'h00;
            state_d       = err_q ? ST_FINISH : ST_FETCH;
         end
         ST_FETCH: begin
            RegRe   = !rd_pend && !out_valid_q;
            BufAddr = {word_idx, 1'b0};
            if (out_valid_q && OutReady && out_last_q) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            Done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
// tb/tb_spi_flash_read_sequencer.sv - scoreboard bench for the flash read sequencer
module tb_spi_flash_read_sequencer;

   localparam int TIMEOUT = 200;
   localparam int POLL    = 4;
   localparam int RD_LAT  = 2;

   logic        FastClk;
   logic        Reset;
   logic        Start;
   logic [23:0] FlashAddr;
   logic [8:0]  Len;
   logic        UseSlowClk;
   logic [8:0]  BufAddr;
   logic [7:0]  WriteData;
   logic        WriteTXBuffer, WriteSPICntLo, WriteSPICntHi, RegWe, RegRe;
   logic [15:0] RXBufData;
   logic        SpiBusy;
   logic [15:0] OutData;
   logic        OutValid, OutReady, OutLast;
   logic        Idle, Done, Error;

   spi_flash_read_sequencer #(
      .TIMEOUT_CYCLES(TIMEOUT), .POLL_INTERVAL(POLL), .RD_LAT(RD_LAT)
   ) dut (
      .FastClk(FastClk), .Reset(Reset), .Start(Start), .FlashAddr(FlashAddr),
      .Len(Len), .UseSlowClk(UseSlowClk), .BufAddr(BufAddr), .WriteData(WriteData),
      .WriteTXBuffer(WriteTXBuffer), .WriteSPICntLo(WriteSPICntLo),
      .WriteSPICntHi(WriteSPICntHi), .RegWe(RegWe), .RegRe(RegRe),
      .RXBufData(RXBufData), .SpiBusy(SpiBusy), .OutData(OutData), .OutValid(OutValid),
      .OutReady(OutReady), .OutLast(OutLast), .Idle(Idle), .Done(Done), .Error(Error)
   );

   initial FastClk = 1'b0;
   always #5 FastClk = ~FastClk;

   typedef struct packed {
      logic [2:0] kind;
      logic [8:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] mask;
      logic        last;
   } word_t;

   localparam logic [2:0] K_TX = 3'b100;
   localparam logic [2:0] K_LO = 3'b010;
   localparam logic [2:0] K_HI = 3'b001;

   wr_t   exp_wr[$];
   word_t exp_out[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt, outvalid_seen, out_idx;
   int hi_prev, hi_last;
   int hold_word, hold_left;
   bit hold_first;
   logic [15:0] hold_ref;
   logic [8:0]  last_re_addr;
   int busy_left;
   bit stuck;
   logic       hist_re   [0:RD_LAT];
   logic [8:0] hist_addr [0:RD_LAT];
   logic       hist_busy [0:RD_LAT];

   function automatic logic [15:0] rx_word(input logic [8:0] a);
      return {a[8:1] ^ 8'h5A, a[8:1] + 8'h37};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: stream sink, SPI controller model, then scoreboard checks at the negedge
   task automatic tick();
      wr_t   e;
      word_t w;
      @(negedge FastClk);
      cyc++;
      if (OutValid && hold_left > 0 && out_idx == hold_word) begin
         if (hold_first) begin
            hold_ref   = OutData;
            hold_first = 1'b0;
         end else begin
            chk("hold_stable", 32'(OutData), 32'(hold_ref));
         end
         chk("hold_no_regre", 32'(RegRe), 32'(0));
         OutReady = 1'b0;
         hold_left--;
      end else begin
         OutReady = 1'b1;
      end
      for (int i = RD_LAT; i > 0; i--) begin
         hist_re[i]   = hist_re[i-1];
         hist_addr[i] = hist_addr[i-1];
         hist_busy[i] = hist_busy[i-1];
      end
      hist_re[0]   = RegRe;
      hist_addr[0] = BufAddr;
      hist_busy[0] = stuck || (busy_left != 0);
      if (hist_re[RD_LAT]) begin
         RXBufData = rx_word(hist_addr[RD_LAT]);
         SpiBusy   = hist_busy[RD_LAT];
      end else begin
         RXBufData = 16'hDEAD;
         SpiBusy   = 1'b1;
      end
      if (RegWe && WriteSPICntHi && WriteData[7]) busy_left = 9;
      else if (busy_left > 0) busy_left--;
      if (RegWe) begin
         chk("write_expected", 32'(exp_wr.size() != 0), 32'(1));
         if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk("reg_write", 32'({WriteTXBuffer, WriteSPICntLo, WriteSPICntHi,
                                  WriteTXBuffer ? BufAddr : 9'd0, WriteData}), 32'(e));
         end
         if (WriteSPICntHi) begin
            hi_prev = hi_last;
            hi_last = cyc;
         end
      end
      if (RegRe) last_re_addr = BufAddr;
      if (OutValid) outvalid_seen++;
      if (OutValid && OutReady) begin
         chk("word_expected", 32'(exp_out.size() != 0), 32'(1));
         if (exp_out.size() != 0) begin
            w = exp_out.pop_front();
            chk("out_data", 32'(OutData & w.mask), 32'(w.data & w.mask));
            chk("out_last", 32'(OutLast), 32'(w.last));
         end
         out_idx++;
      end
      if (Done) done_cnt++;
   endtask

   task automatic queue_xfer(input logic [23:0] a, input logic [8:0] l, input logic s, input bit stk);
      int nw;
      logic [7:0] kk;
      done_cnt = 0;
      outvalid_seen = 0;
      out_idx = 0;
      exp_wr.push_back('{K_TX, 9'd0, 8'h03});
      exp_wr.push_back('{K_TX, 9'd1, a[23:16]});
      exp_wr.push_back('{K_TX, 9'd2, a[15:8]});
      exp_wr.push_back('{K_TX, 9'd3, a[7:0]});
      exp_wr.push_back('{K_LO, 9'd0, 8'h03});
      exp_wr.push_back('{K_HI, 9'd0, 8'hD0 | (s ? 8'h08 : 8'h00)});
      if (!stk) begin
         exp_wr.push_back('{K_LO, 9'd0, l[7:0]});
         exp_wr.push_back('{K_HI, 9'd0, 8'hD2 | (s ? 8'h08 : 8'h00) | {7'd0, l[8]}});
      end
      exp_wr.push_back('{K_HI, 9'd0, 8'h00});
      if (!stk) begin
         nw = int'(l) / 2 + 1;
         for (int k = 0; k < nw; k++) begin
            kk = 8'(k);
            exp_out.push_back('{rx_word({kk, 1'b0}),
                                (k == nw - 1 && !l[0]) ? 16'h00FF : 16'hFFFF,
                                k == nw - 1});
         end
      end
      FlashAddr  = a;
      Len        = l;
      UseSlowClk = s;
      stuck      = stk;
      Start      = 1'b1;
      tick();
      Start = 1'b0;
      chk("error_cleared_on_start", 32'(Error), 32'(0));
   endtask

   task automatic run(input string tag, input logic [23:0] a, input logic [8:0] l,
                      input logic s, input bit stk, input int budget);
      queue_xfer(a, l, s, stk);
      for (int i = 0; i < budget && done_cnt == 0; i++) begin
         if (i == 20) begin
            Start = 1'b1;
            FlashAddr = ~a;
            Len = ~l;
         end else begin
            Start = 1'b0;
         end
         tick();
      end
      Start = 1'b0;
      chk({tag, "_done_seen"}, 32'(done_cnt), 32'(1));
      tick(); tick(); tick();
      chk({tag, "_done_once"}, 32'(done_cnt), 32'(1));
      chk({tag, "_writes_drained"}, 32'(exp_wr.size()), 32'(0));
      chk({tag, "_words_drained"}, 32'(exp_out.size()), 32'(0));
      chk({tag, "_idle"}, 32'(Idle), 32'(1));
      chk({tag, "_error"}, 32'(Error), 32'(stk));
      exp_wr.delete();
      exp_out.delete();
      stuck = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; FlashAddr = '0; Len = '0; UseSlowClk = 1'b0;
      OutReady = 1'b1; RXBufData = 16'hDEAD; SpiBusy = 1'b1;
      busy_left = 0; stuck = 1'b0; hold_left = 0; hold_word = 0; hold_first = 1'b0;
      hold_ref = '0; last_re_addr = '0; hi_prev = 0; hi_last = 0;
      done_cnt = 0; outvalid_seen = 0; out_idx = 0;
      for (int i = 0; i <= RD_LAT; i++) begin
         hist_re[i] = 1'b0; hist_addr[i] = '0; hist_busy[i] = 1'b0;
      end
      tick(); tick(); tick();
      Reset = 1'b0;
      tick();
      chk("reset_outputs", 32'({Idle, RegWe, RegRe, WriteTXBuffer, WriteSPICntLo, WriteSPICntHi,
                                OutValid, OutLast, Done, Error}), 32'(10'b1000000000));

      run("basic", 24'h012345, 9'd3, 1'b0, 1'b0, 400);
      run("len0", 24'hABCDEF, 9'd0, 1'b0, 1'b0, 400);
      run("len511", 24'h100000, 9'd511, 1'b0, 1'b0, 3000);
      chk("len511_final_bufaddr", 32'(last_re_addr), 32'(9'h1FE));

      hold_word = 2; hold_left = 10; hold_first = 1'b1;
      run("hold", 24'h00F00D, 9'd7, 1'b0, 1'b0, 400);
      chk("hold_consumed", 32'(hold_left), 32'(0));

      run("timeout", 24'h777777, 9'd5, 1'b0, 1'b1, 1000);
      chk("timeout_span_ok", 32'((hi_last - hi_prev) >= TIMEOUT && (hi_last - hi_prev) <= TIMEOUT + 2), 32'(1));
      chk("timeout_no_outvalid", 32'(outvalid_seen), 32'(0));

      run("slowclk", 24'h020406, 9'h100, 1'b1, 1'b0, 2000);

      queue_xfer(24'h135790, 9'd5, 1'b0, 1'b0);
      for (int i = 0; i < 200 && exp_wr.size() > 1; i++) tick();
      chk("reached_rd_wait", 32'(exp_wr.size()), 32'(1));
      tick(); tick(); tick();
      Reset = 1'b1;
      tick();
      chk("midreset_outputs", 32'({Idle, RegWe, RegRe, WriteTXBuffer, WriteSPICntLo, WriteSPICntHi,
                                   OutValid, OutLast, Done, Error}), 32'(10'b1000000000));
      Reset = 1'b0;
      exp_wr.delete();
      exp_out.delete();
      tick();
      run("after_reset", 24'h2468AC, 9'd4, 1'b0, 1'b0, 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
